ram_dp_param: RTL and testbench

- Parametrised true dual-port synchronous RAM. Successor to the fixed 8-bit, 640x480-frame line/frame buffer in the ORB image pipeline.
- Adds:
  - configurable width, depth and read latency
  - defined read-during-write and write-write collision behaviour
  - out-of-range address protection
  - per-port read-valid strobes
  - a built-in clear engine that fills the array with a constant after reset or on request, so frame buffers start each frame in a known state.

---
 rtl/ram_dp_param.sv | 160 ++++++++++++++++
 tb/tb_ram_dp_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dp_param.sv
// True dual-port synchronous RAM with configurable read latency, collision rules,
// out-of-range protection, read-valid strobes and a constant-fill clear engine.
module ram_dp_param #(
    parameter int                DATA_W         = 8,
    parameter int                ADDR_W         = 19,
    parameter int                DEPTH          = 307200,
    parameter int                RDW_MODE       = 0,
    parameter int                OUT_REG        = 0,
    parameter int                CLEAR_ON_RESET = 1,
    parameter logic [DATA_W-1:0] CLEAR_VAL      = '0
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic [ADDR_W-1:0] address_a,
    input  logic [DATA_W-1:0] data_a,
    input  logic              wren_a,
    input  logic              rden_a,
    output logic [DATA_W-1:0] q_a,
    output logic              qv_a,
    input  logic [ADDR_W-1:0] address_b,
    input  logic [DATA_W-1:0] data_b,
    input  logic              wren_b,
    input  logic              rden_b,
    output logic [DATA_W-1:0] q_b,
    output logic              qv_b
);

    localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              in_a, in_b;
    logic              we_a, we_b;
    logic              rd_a, rd_b;
    logic              byp_a, byp_b;
    logic [IDX_W-1:0]  idx_a, idx_b, idx_clr;

    logic [DATA_W-1:0] mem_q_a_p1, mem_q_b_p1;
    logic [DATA_W-1:0] wdat_a_p1, wdat_b_p1;
    logic              vld_a_p1, vld_b_p1;
    logic              oob_a_p1, oob_b_p1;
    logic              byp_a_p1, byp_b_p1;
    logic [DATA_W-1:0] rd_a_p1, rd_b_p1;

    logic [DATA_W-1:0] q_hold_a, q_hold_b;
    logic              vld_a_p2, vld_b_p2;

    assign busy = (state == CLEAR);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_a    = ({1'b0, address_a} < DEPTH_X);
    assign in_b    = ({1'b0, address_b} < DEPTH_X);
    assign idx_a   = address_a[IDX_W-1:0];
    assign idx_b   = address_b[IDX_W-1:0];
    assign idx_clr = cnt[IDX_W-1:0];

    // Port A wins a same-address collision, so B's write is suppressed outright.
    assign we_a  = wren_a && !busy && in_a;
    assign we_b  = wren_b && !busy && in_b && !(we_a && (address_a == address_b));
    assign rd_a  = rden_a && !busy;
    assign rd_b  = rden_b && !busy;
    assign byp_a = (RDW_MODE != 0) && we_a;
    assign byp_b = (RDW_MODE != 0) && we_b;

    // Stage p0 -> p1: array access; reads see pre-edge contents (read-first).
    always_ff @(posedge clock) begin
        if (busy) begin
            mem[idx_clr] <= CLEAR_VAL;
        end else begin
            if (we_a) mem[idx_a] <= data_a;
            if (we_b) mem[idx_b] <= data_b;
        end
        if (rd_a && in_a) mem_q_a_p1 <= mem[idx_a];
        if (rd_b && in_b) mem_q_b_p1 <= mem[idx_b];
        wdat_a_p1 <= data_a;
        wdat_b_p1 <= data_b;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            vld_a_p1 <= 1'b0;
            vld_b_p1 <= 1'b0;
            oob_a_p1 <= 1'b0;
            oob_b_p1 <= 1'b0;
            byp_a_p1 <= 1'b0;
            byp_b_p1 <= 1'b0;
        end else begin
            vld_a_p1 <= rd_a;
            vld_b_p1 <= rd_b;
            oob_a_p1 <= !in_a;
            oob_b_p1 <= !in_b;
            byp_a_p1 <= byp_a;
            byp_b_p1 <= byp_b;
        end
    end

    assign rd_a_p1 = oob_a_p1 ? '0 : (byp_a_p1 ? wdat_a_p1 : mem_q_a_p1);
    assign rd_b_p1 = oob_b_p1 ? '0 : (byp_b_p1 ? wdat_b_p1 : mem_q_b_p1);

    // Stage p1 -> p2: hold register doubles as the optional output stage.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            q_hold_a <= '0;
            q_hold_b <= '0;
            vld_a_p2 <= 1'b0;
            vld_b_p2 <= 1'b0;
        end else begin
            if (vld_a_p1) q_hold_a <= rd_a_p1;
            if (vld_b_p1) q_hold_b <= rd_b_p1;
            vld_a_p2 <= vld_a_p1;
            vld_b_p2 <= vld_b_p1;
        end
    end

    assign q_a  = ((OUT_REG != 0) || !vld_a_p1) ? q_hold_a : rd_a_p1;
    assign q_b  = ((OUT_REG != 0) || !vld_b_p1) ? q_hold_b : rd_b_p1;
    assign qv_a = (OUT_REG != 0) ? vld_a_p2 : vld_a_p1;
    assign qv_b = (OUT_REG != 0) ? vld_b_p2 : vld_b_p1;

endmodule

// File: tb/tb_ram_dp_param.sv
// Directed bench for ram_dp_param: two instances share stimulus, one with
// OUT_REG=0/RDW_MODE=0 and one with OUT_REG=1/RDW_MODE=1.
module tb_ram_dp_param;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int DP = 16;
    localparam logic [7:0] CV = 8'hA5;

    logic          clock = 1'b0;
    logic          rst_n;
    logic          clear_req;
    logic [AW-1:0] address_a, address_b;
    logic [DW-1:0] data_a, data_b;
    logic          wren_a, wren_b, rden_a, rden_b;

    logic          busy0, busy1;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
    logic          qv_a0, qv_b0, qv_a1, qv_b1;

    int n_chk = 0;
    int n_err = 0;
    int cycles;
    logic [7:0] mask0, mask1;

    always #5 clock = ~clock;

    ram_dp_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RDW_MODE(0), .OUT_REG(0),
        .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)
    ) dut0 (
        .clock(clock), .rst_n(rst_n), .clear_req(clear_req), .busy(busy0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
        .q_a(q_a0), .qv_a(qv_a0),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
        .q_b(q_b0), .qv_b(qv_b0)
    );

    ram_dp_param #(
        .DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .RDW_MODE(1), .OUT_REG(1),
        .CLEAR_ON_RESET(1), .CLEAR_VAL(CV)
    ) dut1 (
        .clock(clock), .rst_n(rst_n), .clear_req(clear_req), .busy(busy1),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
        .q_a(q_a1), .qv_a(qv_a1),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
        .q_b(q_b1), .qv_b(qv_b1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        clear_req = 1'b0;
        wren_a = 1'b0; wren_b = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        address_a = '0; address_b = '0; data_a = '0; data_b = '0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();

        check("rst_q_a0", q_a0, 8'h00);
        check("rst_qv_a0", qv_a0, 1'b0);
        check("rst_q_b1", q_b1, 8'h00);
        check("rst_qv_b1", qv_b1, 1'b0);
        check("rst_busy0", busy0, 1'b1);

        // Power-on sweep length
        rst_n = 1'b1;
        cycles = 0;
        while (busy0 && cycles < 40) begin
            tick();
            cycles++;
        end
        check("sweep_len", cycles, 16);
        check("sweep_busy1", busy1, 1'b0);

        // Every word holds the clear value, latency 1 on dut0
        for (int i = 0; i < DP; i++) begin
            rden_a = 1'b1;
            address_a = AW'(i);
            tick();
            check("clr_qv_a0", qv_a0, 1'b1);
            check("clr_q_a0", q_a0, CV);
        end
        rden_a = 1'b0;
        tick();
        check("clr_q_a1", q_a1, CV);
        check("clr_qv_a1", qv_a1, 1'b1);
        tick();

        // Write A, read B next cycle: latency 1 vs 2
        wren_a = 1'b1; address_a = 5'd7; data_a = 8'h3C;
        tick();
        wren_a = 1'b0;
        rden_b = 1'b1; address_b = 5'd7;
        tick();
        check("lat_qv_b0", qv_b0, 1'b1);
        check("lat_q_b0", q_b0, 8'h3C);
        check("lat_qv_b1_early", qv_b1, 1'b0);
        rden_b = 1'b0;
        tick();
        check("lat_qv_b0_off", qv_b0, 1'b0);
        check("lat_q_b0_hold", q_b0, 8'h3C);
        check("lat_qv_b1", qv_b1, 1'b1);
        check("lat_q_b1", q_b1, 8'h3C);
        tick();

        // Four back-to-back reads give four consecutive pulses
        mask0 = '0; mask1 = '0;
        for (int j = 0; j < 8; j++) begin
            rden_b = (j < 4);
            tick();
            mask0[j] = qv_b0;
            mask1[j] = qv_b1;
        end
        check("b2b_mask0", mask0, 8'h0F);
        check("b2b_mask1", mask1, 8'h1E);

        // Write-write collision: A wins
        wren_a = 1'b1; address_a = 5'd3; data_a = 8'h11;
        wren_b = 1'b1; address_b = 5'd3; data_b = 8'h22;
        tick();
        wren_a = 1'b0; wren_b = 1'b0;
        rden_a = 1'b1;
        tick();
        check("coll_q_a0", q_a0, 8'h11);
        rden_a = 1'b0;
        tick();
        check("coll_q_a1", q_a1, 8'h11);

        // Read-during-write on addr 5
        wren_a = 1'b1; address_a = 5'd5; data_a = 8'h01;
        tick();
        data_a = 8'h02; rden_a = 1'b1;
        rden_b = 1'b1; address_b = 5'd5;
        tick();
        wren_a = 1'b0; rden_a = 1'b0; rden_b = 1'b0;
        check("rdw_q_a0", q_a0, 8'h01);
        check("rdw_q_b0", q_b0, 8'h01);
        tick();
        check("rdw_q_a1", q_a1, 8'h02);
        check("rdw_q_b1", q_b1, 8'h01);
        rden_a = 1'b1;
        tick();
        rden_a = 1'b0;
        check("rdw_stored0", q_a0, 8'h02);
        tick();

        // Out-of-range write/read; low-bit alias untouched
        wren_a = 1'b1; address_a = 5'd20; data_a = 8'hFF;
        tick();
        wren_a = 1'b0; rden_a = 1'b1;
        rden_b = 1'b1; address_b = 5'd4;
        tick();
        rden_a = 1'b0; rden_b = 1'b0;
        check("oob_q_a0", q_a0, 8'h00);
        check("oob_qv_a0", qv_a0, 1'b1);
        check("alias_q_b0", q_b0, CV);
        tick();
        check("oob_q_a1", q_a1, 8'h00);
        check("oob_qv_a1", qv_a1, 1'b1);
        check("alias_q_b1", q_b1, CV);

        // Load q with a non-zero value, then start a sweep
        rden_a = 1'b1; address_a = 5'd7;
        tick();
        rden_a = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check("req_busy0", busy0, 1'b1);
        check("req_q_a1", q_a1, 8'h3C);
        rden_a = 1'b1; address_a = 5'd7;
        tick();
        rden_a = 1'b0;
        check("busy_rd_qv_a0", qv_a0, 1'b0);
        check("busy_rd_q_a0", q_a0, 8'h3C);
        repeat (4) tick();

        // Asynchronous reset mid-sweep
        rst_n = 1'b0;
        #1;
        check("mid_q_a0", q_a0, 8'h00);
        check("mid_q_a1", q_a1, 8'h00);
        check("mid_qv_a0", qv_a0, 1'b0);
        check("mid_busy0", busy0, 1'b1);
        repeat (2) tick();
        rst_n = 1'b1;
        cycles = 0;
        address_a = 5'd2; data_a = 8'h77;
        while (busy0 && cycles < 40) begin
            wren_a = (cycles == 10);
            tick();
            cycles++;
        end
        wren_a = 1'b0;
        check("resweep_len", cycles, 16);

        rden_a = 1'b1; address_a = 5'd2;
        rden_b = 1'b1; address_b = 5'd7;
        tick();
        rden_a = 1'b0; rden_b = 1'b0;
        check("drop_wr_q_a0", q_a0, CV);
        check("recleared_q_b0", q_b0, CV);
        tick();
        check("drop_wr_q_a1", q_a1, CV);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
